// File: rtl/score_keeper_if.sv
// -----------------------------------------------------------------------------
// score_keeper_if
//   Bundle between the frame-timing/ball logic and the score_keeper rule
//   controller.
//
//   frame        1   one-cycle strobe per frame (start of vertical blank)
//   ball_x       10  ball left-edge x position, stable while frame is high
//   start        1   start/restart request level
//   inc_left     1   stretched increment to the left-score counter
//   inc_right    1   stretched increment to the right-score counter
//   score_clr    1   stretched clear to both score counters
//   serve        1   ball held at centre
//   serve_dir    1   0 = serve toward left, 1 = toward right
//   game_over    1   game finished
//   score_left   7   binary shadow score, left player
//   score_right  7   binary shadow score, right player
//
//   master : the side that produces frame/ball_x/start and consumes the rest
//   slave  : the score_keeper itself
// -----------------------------------------------------------------------------
interface score_keeper_if;
    logic       frame;
    logic [9:0] ball_x;
    logic       start;
    logic       inc_left;
    logic       inc_right;
    logic       score_clr;
    logic       serve;
    logic       serve_dir;
    logic       game_over;
    logic [6:0] score_left;
    logic [6:0] score_right;

    modport master (
        output frame, ball_x, start,
        input  inc_left, inc_right, score_clr, serve, serve_dir, game_over,
               score_left, score_right
    );

    modport slave (
        input  frame, ball_x, start,
        output inc_left, inc_right, score_clr, serve, serve_dir, game_over,
               score_left, score_right
    );
endinterface

// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//   Game-rule controller sitting in front of the two-digit score counters.
//   Samples the ball position once per frame, detects conceded points,
//   produces stretched inc/clear pulses long enough for the slower display
//   counter clock to see, and sequences IDLE -> CLEAR -> SERVE -> PLAY ->
//   POINT -> (SERVE | GAME_OVER). Binary shadow scores are kept locally so
//   that win detection never has to read the display counters back.
//
//   px_clk  in   pixel clock, the only clock
//   reset   in   asynchronous active-low reset
//   sk      slave modport of score_keeper_if (frame/ball_x/start in,
//           pulses, serve/game status and shadow scores out)
//
//   All outputs are registered. PULSE_HOLD must be at least 2 so the shadow
//   score has been updated before the win check at the end of the hold.
// -----------------------------------------------------------------------------
module score_keeper #(
    parameter logic [9:0] FIELD_LEFT   = 10'd8,
    parameter logic [9:0] FIELD_RIGHT  = 10'd631,
    parameter logic [9:0] BALL_SIZE    = 10'd8,
    parameter logic [6:0] WIN_SCORE    = 7'd11,
    parameter logic [7:0] SERVE_FRAMES = 8'd60,
    parameter logic [7:0] PULSE_HOLD   = 8'd16
) (
    input  logic          px_clk,
    input  logic          reset,
    score_keeper_if.slave sk
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_SERVE     = 3'd2,
        ST_PLAY      = 3'd3,
        ST_POINT     = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    // Shadow scores stop at 99, the largest value a two-digit counter shows.
    function automatic logic [6:0] sat_inc(input logic [6:0] value);
        logic [6:0] result;
        if (value >= 7'd99) begin
            result = 7'd99;
        end else begin
            result = value + 7'd1;
        end
        return result;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  frame_cnt_r;
    logic [7:0]  frame_cnt_next_s;
    logic [7:0]  hold_cnt_r;
    logic [7:0]  hold_cnt_next_s;
    logic        scorer_r;        // 1 = right player scored, 0 = left
    logic        scorer_next_s;

    logic [6:0]  score_left_r;
    logic [6:0]  score_right_r;
    logic        inc_left_r;
    logic        inc_right_r;
    logic        score_clr_r;
    logic        serve_r;
    logic        serve_dir_r;
    logic        game_over_r;

    logic [10:0] ball_right_edge_s;
    logic        out_left_s;
    logic        out_right_s;
    logic        win_s;
    logic        hold_done_s;

    // Field-edge checks; the right edge is summed at 11 bits so it cannot wrap.
    always_comb begin
        ball_right_edge_s = {1'b0, sk.ball_x} + {1'b0, BALL_SIZE};
        out_left_s        = (sk.ball_x <= FIELD_LEFT);
        out_right_s       = (ball_right_edge_s > {1'b0, FIELD_RIGHT});
        hold_done_s       = (hold_cnt_r == (PULSE_HOLD - 8'd1));
        if (scorer_r) begin
            win_s = (score_right_r == WIN_SCORE);
        end else begin
            win_s = (score_left_r == WIN_SCORE);
        end
    end

    // Next-state logic for the game sequencer and its counters.
    always_comb begin
        state_next_s     = state_r;
        frame_cnt_next_s = frame_cnt_r;
        hold_cnt_next_s  = hold_cnt_r;
        scorer_next_s    = scorer_r;
        case (state_r)
            ST_IDLE: begin
                if (sk.start) begin
                    state_next_s    = ST_CLEAR;
                    hold_cnt_next_s = 8'd0;
                end else begin
                    state_next_s    = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (hold_done_s) begin
                    state_next_s     = ST_SERVE;
                    frame_cnt_next_s = 8'd0;
                    hold_cnt_next_s  = 8'd0;
                end else begin
                    hold_cnt_next_s  = hold_cnt_r + 8'd1;
                end
            end
            ST_SERVE: begin
                if (sk.frame) begin
                    if ((frame_cnt_r + 8'd1) == SERVE_FRAMES) begin
                        state_next_s     = ST_PLAY;
                        frame_cnt_next_s = 8'd0;
                    end else begin
                        frame_cnt_next_s = frame_cnt_r + 8'd1;
                    end
                end else begin
                    frame_cnt_next_s = frame_cnt_r;
                end
            end
            ST_PLAY: begin
                if (sk.frame) begin
                    // Left-edge check first: it wins if both could be true.
                    if (out_left_s) begin
                        state_next_s    = ST_POINT;
                        scorer_next_s   = 1'b1;
                        hold_cnt_next_s = 8'd0;
                    end else if (out_right_s) begin
                        state_next_s    = ST_POINT;
                        scorer_next_s   = 1'b0;
                        hold_cnt_next_s = 8'd0;
                    end else begin
                        state_next_s    = ST_PLAY;
                    end
                end else begin
                    state_next_s = ST_PLAY;
                end
            end
            ST_POINT: begin
                if (hold_done_s) begin
                    hold_cnt_next_s = 8'd0;
                    if (win_s) begin
                        state_next_s     = ST_GAME_OVER;
                    end else begin
                        state_next_s     = ST_SERVE;
                        frame_cnt_next_s = 8'd0;
                    end
                end else begin
                    hold_cnt_next_s = hold_cnt_r + 8'd1;
                end
            end
            ST_GAME_OVER: begin
                if (sk.start) begin
                    state_next_s    = ST_CLEAR;
                    hold_cnt_next_s = 8'd0;
                end else begin
                    state_next_s    = ST_GAME_OVER;
                end
            end
            default: begin
                state_next_s     = ST_IDLE;
                frame_cnt_next_s = 8'd0;
                hold_cnt_next_s  = 8'd0;
                scorer_next_s    = 1'b0;
            end
        endcase
    end

    // Sequencer state and counter registers.
    always_ff @(posedge px_clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            frame_cnt_r <= 8'd0;
            hold_cnt_r  <= 8'd0;
            scorer_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            frame_cnt_r <= frame_cnt_next_s;
            hold_cnt_r  <= hold_cnt_next_s;
            scorer_r    <= scorer_next_s;
        end
    end

    // Shadow scores: zeroed on the first CLEAR cycle, bumped on the first POINT cycle.
    always_ff @(posedge px_clk or negedge reset) begin
        if (!reset) begin
            score_left_r  <= 7'd0;
            score_right_r <= 7'd0;
        end else if ((state_r == ST_CLEAR) && (hold_cnt_r == 8'd0)) begin
            score_left_r  <= 7'd0;
            score_right_r <= 7'd0;
        end else if ((state_r == ST_POINT) && (hold_cnt_r == 8'd0)) begin
            if (scorer_r) begin
                score_right_r <= sat_inc(score_right_r);
            end else begin
                score_left_r  <= sat_inc(score_left_r);
            end
        end else begin
            score_left_r  <= score_left_r;
            score_right_r <= score_right_r;
        end
    end

    // Registered outputs decoded from the next state so they line up with the state register.
    always_ff @(posedge px_clk or negedge reset) begin
        if (!reset) begin
            inc_left_r  <= 1'b0;
            inc_right_r <= 1'b0;
            score_clr_r <= 1'b0;
            serve_r     <= 1'b1;
            serve_dir_r <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            inc_left_r  <= (state_next_s == ST_POINT) && !scorer_next_s;
            inc_right_r <= (state_next_s == ST_POINT) &&  scorer_next_s;
            score_clr_r <= (state_next_s == ST_CLEAR);
            serve_r     <= (state_next_s != ST_PLAY);
            game_over_r <= (state_next_s == ST_GAME_OVER);
            // Serve goes toward whoever conceded: right scored -> 0.
            if (state_next_s == ST_CLEAR) begin
                serve_dir_r <= 1'b0;
            end else if ((state_r == ST_PLAY) && (state_next_s == ST_POINT)) begin
                serve_dir_r <= !scorer_next_s;
            end else begin
                serve_dir_r <= serve_dir_r;
            end
        end
    end

    assign sk.inc_left    = inc_left_r;
    assign sk.inc_right   = inc_right_r;
    assign sk.score_clr   = score_clr_r;
    assign sk.serve       = serve_r;
    assign sk.serve_dir   = serve_dir_r;
    assign sk.game_over   = game_over_r;
    assign sk.score_left  = score_left_r;
    assign sk.score_right = score_right_r;

endmodule

// File: tb/tb_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_score_keeper
//   Directed bench for score_keeper: reset/idle, start and clear, serve
//   countdown, field-edge boundaries, win and restart, asynchronous reset in
//   the middle of a pulse. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_score_keeper;

    logic px_clk = 1'b0;
    logic reset  = 1'b0;

    score_keeper_if sk_if ();

    score_keeper dut (
        .px_clk (px_clk),
        .reset  (reset),
        .sk     (sk_if.slave)
    );

    always #5 px_clk = ~px_clk;

    int check_cnt = 0;
    int fail_cnt  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge px_clk);
        #1;
    endtask

    task automatic send_frame(input logic [9:0] x);
        sk_if.ball_x = x;
        sk_if.frame  = 1'b1;
        tick();
        sk_if.frame  = 1'b0;
        repeat (3) tick();
    endtask

    task automatic serve_out;
        repeat (60) send_frame(10'd320);
    endtask

    // One frame strobe, then count pulse-line high cycles over a fixed window.
    task automatic strobe_count(input logic [9:0] x, output int nl, output int nr, output int nc);
        nl = 0; nr = 0; nc = 0;
        sk_if.ball_x = x;
        sk_if.frame  = 1'b1;
        tick();
        sk_if.frame  = 1'b0;
        repeat (30) begin
            nl += int'(sk_if.inc_left);
            nr += int'(sk_if.inc_right);
            nc += int'(sk_if.score_clr);
            tick();
        end
    endtask

    // Assert start for one cycle (or keep it high) and count pulse lines.
    task automatic start_count(input bit hold_start, output int nl, output int nr, output int nc);
        nl = 0; nr = 0; nc = 0;
        sk_if.start = 1'b1;
        tick();
        if (!hold_start) sk_if.start = 1'b0;
        repeat (40) begin
            nl += int'(sk_if.inc_left);
            nr += int'(sk_if.inc_right);
            nc += int'(sk_if.score_clr);
            tick();
        end
        sk_if.start = 1'b0;
    endtask

    int nl, nr, nc;

    initial begin
        sk_if.frame  = 1'b0;
        sk_if.ball_x = 10'd0;
        sk_if.start  = 1'b0;

        // 1: reset and idle
        repeat (3) tick();
        check_val("rst_serve", sk_if.serve, 1);
        check_val("rst_clr", sk_if.score_clr, 0);
        reset = 1'b1;
        repeat (100) send_frame(10'd5);
        check_val("idle_serve", sk_if.serve, 1);
        check_val("idle_inc_l", sk_if.inc_left, 0);
        check_val("idle_inc_r", sk_if.inc_right, 0);
        check_val("idle_clr", sk_if.score_clr, 0);
        check_val("idle_go", sk_if.game_over, 0);
        check_val("idle_sl", sk_if.score_left, 0);
        check_val("idle_sr", sk_if.score_right, 0);

        // 2: start, clear pulse, serve countdown
        start_count(1'b0, nl, nr, nc);
        check_val("clr_len", nc, 16);
        check_val("clr_incs", nl + nr, 0);
        check_val("clr_dir", sk_if.serve_dir, 0);
        repeat (59) send_frame(10'd320);
        check_val("serve_59", sk_if.serve, 1);
        sk_if.frame = 1'b1;
        tick();
        sk_if.frame = 1'b0;
        check_val("serve_60", sk_if.serve, 0);
        repeat (3) tick();

        // 3: right player scores
        strobe_count(10'd5, nl, nr, nc);
        check_val("p3_inc_r", nr, 16);
        check_val("p3_inc_l", nl, 0);
        check_val("p3_sr", sk_if.score_right, 1);
        check_val("p3_dir", sk_if.serve_dir, 0);
        check_val("p3_serve", sk_if.serve, 1);

        // 4: field-edge boundaries
        serve_out();
        strobe_count(10'd623, nl, nr, nc);
        check_val("b623_none", nl + nr + nc, 0);
        strobe_count(10'd625, nl, nr, nc);
        check_val("b625_inc_l", nl, 16);
        check_val("b625_inc_r", nr, 0);
        check_val("b625_sl", sk_if.score_left, 1);
        check_val("b625_dir", sk_if.serve_dir, 1);
        serve_out();
        strobe_count(10'd9, nl, nr, nc);
        check_val("b9_none", nl + nr + nc, 0);
        strobe_count(10'd8, nl, nr, nc);
        check_val("b8_inc_r", nr, 16);
        check_val("b8_sr", sk_if.score_right, 2);
        serve_out();
        strobe_count(10'd624, nl, nr, nc);
        check_val("b624_inc_l", nl, 16);
        check_val("b624_sl", sk_if.score_left, 2);
        serve_out();
        strobe_count(10'd1023, nl, nr, nc);
        check_val("b1023_inc_l", nl, 16);
        check_val("b1023_sl", sk_if.score_left, 3);

        // 5: right player reaches 11, game over, restart
        for (int k = 3; k <= 11; k++) begin
            serve_out();
            strobe_count(10'd5, nl, nr, nc);
            check_val("win_inc_r", nr, 16);
            check_val("win_go", sk_if.game_over, (k == 11) ? 1 : 0);
        end
        check_val("win_sr", sk_if.score_right, 11);
        check_val("win_sl", sk_if.score_left, 3);
        check_val("win_serve", sk_if.serve, 1);
        strobe_count(10'd5, nl, nr, nc);
        check_val("go_frozen_inc", nl + nr + nc, 0);
        check_val("go_frozen_sr", sk_if.score_right, 11);
        start_count(1'b1, nl, nr, nc);
        check_val("rs_clr_len", nc, 16);
        check_val("rs_incs", nl + nr, 0);
        check_val("rs_sl", sk_if.score_left, 0);
        check_val("rs_sr", sk_if.score_right, 0);
        check_val("rs_go", sk_if.game_over, 0);
        check_val("rs_serve", sk_if.serve, 1);
        check_val("rs_dir", sk_if.serve_dir, 0);
        serve_out();
        strobe_count(10'd5, nl, nr, nc);
        check_val("rs_play_inc_r", nr, 16);
        check_val("rs_play_sr", sk_if.score_right, 1);

        // 6: asynchronous reset in the 8th cycle of an inc_left pulse
        serve_out();
        sk_if.ball_x = 10'd625;
        sk_if.frame  = 1'b1;
        tick();
        sk_if.frame  = 1'b0;
        repeat (7) tick();
        check_val("ar_pre", sk_if.inc_left, 1);
        #2;
        reset = 1'b0;
        #1;
        check_val("ar_inc_l", sk_if.inc_left, 0);
        check_val("ar_sl", sk_if.score_left, 0);
        check_val("ar_sr", sk_if.score_right, 0);
        check_val("ar_serve", sk_if.serve, 1);
        check_val("ar_go", sk_if.game_over, 0);
        tick();
        reset = 1'b1;
        tick();
        strobe_count(10'd5, nl, nr, nc);
        check_val("ar_idle_pulses", nl + nr + nc, 0);
        check_val("ar_idle_serve", sk_if.serve, 1);

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-rule controller directly upstream of the two-digit score counters.
- Samples ball position once per frame and detects when a player concedes a point.
- Generates stretched increment and reset pulses for the left and right counters, and sequences serve / play / game-over.
- Keeps binary shadow scores so win detection needs no readback from the display counters.

Parameters:
FIELD_LEFT, 10'd8, ball_x at or below this value scores a point for the right player
FIELD_RIGHT, 10'd631, ball_x + BALL_SIZE above this value scores a point for the left player
BALL_SIZE, 10'd8, ball width in pixels
WIN_SCORE, 7'd11, score that ends the game (range 1..99)
SERVE_FRAMES, 8'd60, frames the ball is held before release
PULSE_HOLD, 8'd16, px_clk cycles each inc/clr pulse is held, so the slower dyn_clk domain samples it

Ports:
px_clk  input  1  pixel clock; the only clock
reset  input  1  asynchronous, active-low reset
frame  input  1  one-cycle strobe per frame, start of vertical blank
ball_x  input  10  ball left-edge x position, stable while frame is high
start  input  1  start/restart request, level, synchronised upstream
inc_left  output  1  increment to the left-score counter, held PULSE_HOLD cycles
inc_right  output  1  increment to the right-score counter, held PULSE_HOLD cycles
score_clr  output  1  clear to both counters, held PULSE_HOLD cycles
serve  output  1  high while the ball is to be held at centre
serve_dir  output  1  0 = serve toward left, 1 = toward right
game_over  output  1  high in GAME_OVER state
score_left  output  7  binary shadow score, left player
score_right  output  7  binary shadow score, right player

Behaviour:
- Reset (reset low, asynchronous): state IDLE; all outputs 0 except serve = 1; scores 0; frame and hold counters 0.
- States: IDLE, CLEAR, SERVE, PLAY, POINT, GAME_OVER.
- IDLE: on start = 1, go to CLEAR.
- CLEAR:
  - score_clr = 1 for exactly PULSE_HOLD cycles.
  - score_left and score_right are zeroed on the first CLEAR cycle.
  - Then go to SERVE with frame counter = 0; serve_dir = 0.
- SERVE:
  - serve = 1.
  - Frame counter increments on each frame strobe.
  - On the frame strobe that makes the count equal SERVE_FRAMES, go to PLAY next cycle and clear the counter.
  - Frames between SERVE entry and the next strobe are not counted as partial frames.
- PLAY:
  - serve = 0.
  - ball_x is evaluated only on cycles where frame = 1.
  - ball_x <= FIELD_LEFT: point to the right player.
  - Else, ball_x + BALL_SIZE > FIELD_RIGHT, with the sum computed at 11 bits (no wrap): point to the left player.
  - If both conditions could hold, the left-edge check wins.
  - On a point, go to POINT.
- POINT:
  - The scorer's inc line is high for exactly PULSE_HOLD cycles.
  - The scorer's shadow score increments by 1 on the first POINT cycle.
  - serve_dir is set toward the conceding player: right scored -> serve_dir = 0.
  - After the hold: if the new score == WIN_SCORE go to GAME_OVER, else go to SERVE with frame counter = 0.
- GAME_OVER:
  - game_over = 1; serve = 1.
  - Scores are frozen; frame strobes are ignored.
  - On start = 1, go to CLEAR.
- inc_left, inc_right and score_clr are mutually exclusive; never more than one is high in any cycle.
- Pulse lines are registered outputs; the first high cycle is the cycle after the transition into POINT or CLEAR.
- start is ignored in SERVE, PLAY, POINT and CLEAR.
- A start held high through CLEAR does not retrigger a second clear.
- Shadow scores saturate at 99; this is unreachable when WIN_SCORE <= 99.
- Reset mid-pulse terminates the pulse immediately (asynchronous) and returns to IDLE.

Test Plan:
1. Reset low then high, no start, 100 frames -> state IDLE, serve = 1, inc_left / inc_right / score_clr all 0, scores 0.
2. Pulse start, then 60 frame strobes -> score_clr high exactly 16 cycles; serve falls the cycle after the 60th strobe.
3. In PLAY, present ball_x = 5 on a frame strobe -> inc_right high 16 cycles, score_right = 1, serve_dir = 0, serve = 1; inc_left never asserts.
4. In PLAY, present ball_x = 625 (625 + 8 > 631) -> inc_left 16 cycles, score_left = 1; ball_x = 623 -> no point.
5. Score right player 11 times -> game_over = 1 after the 11th pulse; further out-of-field frames produce no inc; start -> score_clr 16 cycles, scores 0, state SERVE.
6. Drive reset low during the 8th cycle of an inc_left pulse -> inc_left drops without waiting for a clock edge; state IDLE; scores 0.
